fetch_control: RTL

- PC/fetch sequencer directly upstream of the instruction memory.
- Drives the memory's pc, branch and branchamount inputs every cycle and tracks which address produced the memory's registered readdata.
- Uses that registered readdata as the IF/ID instruction register and publishes the matching PC and valid bit to decode.
- Handles taken ID-stage branches (zero-bubble, via the memory's branch mode), decode stalls (address replay), and later-stage redirects.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_control_if.sv | 40 ++++
 rtl/fetch_addr_sel.sv | 50 +++++
 rtl/fetch_control.sv | 87 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int PC_W     = 32;
    localparam int BR_AMT_W = 6;
    localparam int INSTR_W  = 32;

    localparam logic [PC_W-1:0] PC_STEP      = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_control_if.sv
// Signal bundle between the fetch sequencer, instruction memory, decode and hazard/redirect logic.
// Latency: n/a (wires only).
// Backpressure: stall from the hazard unit holds ID; the memory itself never backpressures.
interface fetch_control_if
    import fetch_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic                stall;
    logic                br_take;
    logic [BR_AMT_W-1:0] br_amount;
    logic                redir_valid;
    logic [PC_W-1:0]     redir_pc;
    logic [INSTR_W-1:0]  imem_rdata;

    logic [PC_W-1:0]     imem_pc;
    logic                imem_branch;
    logic [BR_AMT_W-1:0] imem_branchamount;
    logic [INSTR_W-1:0]  id_instr;
    logic [PC_W-1:0]     id_pc;
    logic [PC_W-1:0]     id_pc4;
    logic                id_valid;
    logic [CNT_W-1:0]    fetch_count;

    // Fetch sequencer side.
    modport master (
        input  stall, br_take, br_amount, redir_valid, redir_pc, imem_rdata,
        output imem_pc, imem_branch, imem_branchamount,
        output id_instr, id_pc, id_pc4, id_valid, fetch_count
    );

    // Environment side: memory, decode, hazard unit, redirect source.
    modport slave (
        output stall, br_take, br_amount, redir_valid, redir_pc, imem_rdata,
        input  imem_pc, imem_branch, imem_branchamount,
        input  id_instr, id_pc, id_pc4, id_valid, fetch_count
    );

endinterface

// File: rtl/fetch_addr_sel.sv
// Priority mux for the memory request and the next ID pc: redirect > boot > stall > branch > sequential.
// Latency: purely combinational.
// Backpressure: stall replays cur_pc so the registered readdata and ID stay put.
module fetch_addr_sel
    import fetch_pkg::*;
(
    input  logic                boot,
    input  logic [PC_W-1:0]     cur_pc,
    input  logic                stall,
    input  logic                br_take,
    input  logic [BR_AMT_W-1:0] br_amount,
    input  logic                redir_valid,
    input  logic [PC_W-1:0]     redir_pc,
    output logic [PC_W-1:0]     imem_pc,
    output logic                imem_branch,
    output logic [BR_AMT_W-1:0] imem_branchamount,
    output logic [PC_W-1:0]     pc_nxt
);

    logic [PC_W-1:0] redir_al;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;

    // Word-align the redirect target; all pc math wraps modulo 2^32.
    assign redir_al = redir_pc & {{(PC_W-2){1'b1}}, 2'b00};
    assign seq_pc   = cur_pc + PC_STEP;
    assign br_pc    = seq_pc + {{(PC_W-BR_AMT_W-2){1'b0}}, br_amount, 2'b00};

    // A taken branch presents cur_pc in the memory's branch mode, so the
    // target word arrives next cycle and cur_pc+4 is never fetched.
    always_comb begin
        imem_pc           = seq_pc;
        imem_branch       = 1'b0;
        imem_branchamount = '0;
        pc_nxt            = seq_pc;
        if (redir_valid) begin
            imem_pc = redir_al;
            pc_nxt  = redir_al;
        end else if (boot || stall) begin
            imem_pc = cur_pc;
            pc_nxt  = cur_pc;
        end else if (br_take) begin
            imem_pc           = cur_pc;
            imem_branch       = 1'b1;
            imem_branchamount = br_amount;
            pc_nxt            = br_pc;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// PC/fetch sequencer: drives instruction memory and tracks the pc of its registered readdata for ID.
// Latency: an instruction reaches ID exactly one cycle after its address is presented.
// Backpressure: stall replays the ID pc to the memory and freezes pc, readdata and fetch_count.
module fetch_control
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    fetch_control_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  cur_pc;
    logic [PC_W-1:0]  pc_nxt;
    logic             cur_valid;
    logic [CNT_W-1:0] fetch_count;
    logic             count_en;
    logic             redir_eff;

    // Redirects are ignored while reset is held so the memory sees RESET_PC.
    assign redir_eff = bus.redir_valid & ~reset;

    fetch_addr_sel u_addr_sel (
        .boot              (state == BOOT),
        .cur_pc            (cur_pc),
        .stall             (bus.stall),
        .br_take           (bus.br_take),
        .br_amount         (bus.br_amount),
        .redir_valid       (redir_eff),
        .redir_pc          (bus.redir_pc),
        .imem_pc           (bus.imem_pc),
        .imem_branch       (bus.imem_branch),
        .imem_branchamount (bus.imem_branchamount),
        .pc_nxt            (pc_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one boot cycle, then run until reset.
    always_comb begin
        state_nxt = state;
        if (state == BOOT) begin
            state_nxt = RUN;
        end
    end

    // A new instruction is delivered on every edge except a stalled, unredirected one.
    always_comb begin
        count_en = 1'b1;
        if (state == RUN && bus.stall && !bus.redir_valid) begin
            count_en = 1'b0;
        end
    end

    // Pc/valid/count tracking for the word now registered in the memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_pc      <= RESET_PC;
            cur_valid   <= 1'b0;
            fetch_count <= '0;
        end else begin
            cur_pc    <= pc_nxt;
            cur_valid <= 1'b1;
            if (count_en) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

    assign bus.id_instr    = bus.imem_rdata;
    assign bus.id_pc       = cur_pc;
    assign bus.id_pc4      = cur_pc + PC_STEP;
    assign bus.id_valid    = cur_valid;
    assign bus.fetch_count = fetch_count;

endmodule
